// File: rtl/pipeline_hazard_unit_if.sv
// Decode-stage hazard interface: issue/operand requests in, stall/forwarding/status out.
interface pipeline_hazard_unit_if #(
  parameter int NREGS = 32,
  parameter int DEPTH = 3
);
  localparam int RW = $clog2(NREGS);
  localparam int FW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic              advance;
  logic              flush;
  logic              issue_valid;
  logic              issue_wen;
  logic [RW-1:0]     issue_wsel;
  logic [FW-1:0]     issue_lat;
  logic              use1;
  logic              use2;
  logic [RW-1:0]     rsel1;
  logic [RW-1:0]     rsel2;
  logic              stall;
  logic [FW-1:0]     fwd1;
  logic [FW-1:0]     fwd2;
  logic [NREGS-1:0]  busy;
  logic [CW-1:0]     inflight;
  logic [31:0]       stall_cycles;
  logic [31:0]       flush_events;

  modport master (
    output advance, flush, issue_valid, issue_wen, issue_wsel, issue_lat,
           use1, use2, rsel1, rsel2,
    input  stall, fwd1, fwd2, busy, inflight, stall_cycles, flush_events
  );

  modport slave (
    input  advance, flush, issue_valid, issue_wen, issue_wsel, issue_lat,
           use1, use2, rsel1, rsel2,
    output stall, fwd1, fwd2, busy, inflight, stall_cycles, flush_events
  );
endinterface

// File: rtl/pipeline_hazard_unit.sv
// Hazard scoreboard: tracks in-flight destination registers after decode,
// selects operand forwarding sources, stalls on load-use, squashes on flush.
module pipeline_hazard_unit #(
  parameter int NREGS       = 32,
  parameter int DEPTH       = 3,
  parameter int FLUSH_DEPTH = 1
) (
  input  logic                  CLK,
  input  logic                  nRST,
  pipeline_hazard_unit_if.slave hz
);
  localparam int RW = $clog2(NREGS);
  localparam int FW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  // Entry 0 is the youngest (EX), entry DEPTH-1 the oldest (WB).
  logic [DEPTH-1:0]         valid;
  logic [DEPTH-1:0][RW-1:0] wsel;
  logic [DEPTH-1:0][FW-1:0] lat;

  logic [1:0]               use_v;
  logic [1:0][RW-1:0]       rsel_v;
  logic [1:0][FW-1:0]       fwd_v;
  logic [1:0]               unres;
  logic                     stall_c;
  logic                     new_valid;
  logic [NREGS-1:0]         busy_c;
  logic [CW-1:0]            inflight_c;

  assign use_v  = {hz.use2, hz.use1};
  assign rsel_v = {hz.rsel2, hz.rsel1};

  // Per-operand lookup: youngest matching producer decides forward/stall.
  always_comb begin
    fwd_v = '0;
    unres = '0;
    for (int unsigned s = 0; s < 2; s++) begin
      logic        found;
      int unsigned pos;
      int unsigned need;
      found = 1'b0;
      pos   = 0;
      need  = 1;
      if (use_v[s] && rsel_v[s] != '0) begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
          if (!found && valid[i] && wsel[i] == rsel_v[s]) begin
            found = 1'b1;
            pos   = i;
            need  = (lat[i] == '0) ? 1 : int'(lat[i]);
          end
        end
        // Producer advances one stage before the consumer reads in EX.
        if (found && (pos + 1) < DEPTH) begin
          if ((pos + 1) >= need) fwd_v[s] = FW'(pos + 1);
          else                   unres[s] = 1'b1;
        end
      end
    end
  end

  // Stall decision and admission of the decode instruction into entry 0.
  always_comb begin
    stall_c   = hz.issue_valid & ~hz.flush & (|unres);
    new_valid = hz.issue_valid & ~stall_c & ~hz.flush & hz.issue_wen &
                (hz.issue_wsel != '0);
  end

  // Busy vector and occupancy count from the registered entries.
  always_comb begin
    int unsigned cnt;
    busy_c = '0;
    cnt    = 0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (valid[i]) begin
        busy_c[wsel[i]] = 1'b1;
        cnt = cnt + 1;
      end
    end
    inflight_c = CW'(cnt);
  end

  assign hz.stall    = stall_c;
  assign hz.fwd1     = fwd_v[0];
  assign hz.fwd2     = fwd_v[1];
  assign hz.busy     = busy_c;
  assign hz.inflight = inflight_c;

  // Entry shift/hold with flush squashing of the youngest entries.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      valid <= '0;
      wsel  <= '0;
      lat   <= '0;
    end else if (hz.advance) begin
      for (int unsigned i = 1; i < DEPTH; i++) begin
        valid[i] <= valid[i-1] & ~(hz.flush && (i - 1) < FLUSH_DEPTH);
        wsel[i]  <= wsel[i-1];
        lat[i]   <= lat[i-1];
      end
      valid[0] <= new_valid;
      wsel[0]  <= hz.issue_wsel;
      lat[0]   <= hz.issue_lat;
    end else if (hz.flush) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (i < FLUSH_DEPTH) valid[i] <= 1'b0;
      end
    end
  end

  // Saturating performance counters.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      hz.stall_cycles <= '0;
      hz.flush_events <= '0;
    end else begin
      if (stall_c && hz.advance && hz.stall_cycles != '1)
        hz.stall_cycles <= hz.stall_cycles + 32'd1;
      if (hz.flush && hz.flush_events != '1)
        hz.flush_events <= hz.flush_events + 32'd1;
    end
  end
endmodule
